// File: rtl/cp0_ctrl.sv
// Coprocessor-0 interrupt/exception controller: SR, Cause, EPC and PRId registers, with exception-entry request and eret handling.
// Optional macro CP0_BD_EN enables Cause.BD and the branch-delay-slot EPC adjustment.
module cp0_ctrl #(
   parameter logic [31:0] PRID = 32'h1935_0001
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  addr,
   input  logic        WE,
   input  logic [31:0] DATA_in,
   output logic [31:0] DATA_out,
   input  logic [31:0] PC,
   input  logic        BD_in,
   input  logic [4:0]  ExcCode_in,
   input  logic [5:0]  HWInt,
   input  logic        EXL_clr,
   output logic        Req,
   output logic [31:0] EPC_out
);

   logic [5:0]  r_im;
   logic        r_exl;
   logic        r_ie;
   logic [5:0]  r_ip;
   logic [4:0]  r_exc_code;
   logic        r_bd;
   logic [29:0] r_epc;

   logic        w_int_pend;
   logic        w_exc_pend;
   logic        w_we_sr;
   logic        w_we_epc;
   logic [31:0] w_ret_pc;
   logic        w_bd_new;
   logic        w_unused_bits;

   assign w_int_pend = (|(r_ip & r_im)) & r_ie & ~r_exl;
   assign w_exc_pend = (ExcCode_in != 5'd0) & ~r_exl;
   assign Req        = w_int_pend | w_exc_pend;
   assign w_we_sr    = WE & (addr == 5'd12);
   assign w_we_epc   = WE & (addr == 5'd14);
   assign EPC_out    = {r_epc, 2'b00};

`ifdef CP0_BD_EN
   // A delay-slot instruction must restart at its branch so the branch is re-executed.
   assign w_ret_pc = BD_in ? (PC - 32'd4) : PC;
   assign w_bd_new = BD_in;
`else
   assign w_ret_pc = PC;
   assign w_bd_new = 1'b0;
`endif

   assign w_unused_bits = ^{BD_in, w_ret_pc[1:0]};

   // mfc0 read mux over the pre-edge register values
   always_comb begin
      DATA_out = 32'd0;
      case (addr)
         5'd12:   DATA_out = {16'd0, r_im, 8'd0, r_exl, r_ie};
         5'd13:   DATA_out = {r_bd, 15'd0, r_ip, 3'd0, r_exc_code, 2'b00};
         5'd14:   DATA_out = {r_epc, 2'b00};
         5'd15:   DATA_out = PRID;
         default: DATA_out = 32'd0;
      endcase
   end

   // Register update: exception entry overrides any mtc0 write from the flushed instruction
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_im       <= 6'd0;
         r_exl      <= 1'b0;
         r_ie       <= 1'b0;
         r_ip       <= 6'd0;
         r_exc_code <= 5'd0;
         r_bd       <= 1'b0;
         r_epc      <= 30'd0;
      end else begin
         r_ip <= HWInt;
         if (Req) begin
            r_exl      <= 1'b1;
            r_exc_code <= w_int_pend ? 5'd0 : ExcCode_in;
            r_epc      <= w_ret_pc[31:2];
            r_bd       <= w_bd_new;
         end else begin
            if (w_we_sr) begin
               r_im  <= DATA_in[15:10];
               r_ie  <= DATA_in[0];
               r_exl <= DATA_in[1] & ~EXL_clr;
            end else if (EXL_clr) begin
               r_exl <= 1'b0;
            end
            if (w_we_epc) begin
               r_epc <= DATA_in[31:2];
            end
         end
      end
   end

endmodule

// File: doc/cp0_ctrl.md
# cp0_ctrl

Coprocessor-0 interrupt/exception controller: the CPU-side consumer of the IRQ lines driven by memory-mapped devices (timers, UART, etc.). Latches pending hardware interrupts, masks them against the status register, requests exception entry from the pipeline and records the return state. Sits beside the M stage, accessed by `mfc0`/`mtc0`, cleared by `eret`.

## Interface
- `PRID`, default 32'h1935_0001: constant returned by the PRId register.
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  asynchronous, active-low; clears all registers immediately
- `addr`  in  5  CP0 register number for read and write (12 SR, 13 Cause, 14 EPC, 15 PRId)
- `WE`  in  1  `mtc0` write strobe
- `DATA_in`  in  32  `mtc0` write data
- `DATA_out`  out  32  `mfc0` read data, combinational from `addr`
- `PC`  in  32  address of the M-stage instruction
- `BD_in`  in  1  M-stage instruction sits in a branch delay slot
- `ExcCode_in`  in  5  internal exception code of M-stage instruction, 0 = none
- `HWInt`  in  6  device IRQ lines, bit 0 = timer 0 (Cause.IP[10])
- `EXL_clr`  in  1  `eret` in M stage
- `Req`  out  1  take exception this cycle; pipeline flushes and fetches handler
- `EPC_out`  out  32  current EPC, for `eret` redirect

## Operation
- SR (12): IM[15:10], EXL[1], IE[0] stored; other bits read 0. Writable via `mtc0`.
- Cause (13): BD[31], IP[15:10], ExcCode[6:2]; other bits 0. Read-only to software.
- EPC (14): bits 31:2 stored, bits 1:0 read 0. Writable via `mtc0`.
- PRId (15): `PRID`. Writes ignored. Any other `addr` reads 0.
- IP: Cause.IP <= `HWInt` every cycle (registered, one-cycle latency); level-sensitive, no latching beyond one cycle; device holds IRQ until serviced.
- IntPend = |(Cause.IP & SR.IM) & SR.IE & !SR.EXL.
- ExcPend = (`ExcCode_in` != 0) & !SR.EXL.
- `Req` = IntPend | ExcPend, combinational.
- On a cycle with `Req`=1: EXL<=1; ExcCode <= IntPend ? 0 : `ExcCode_in` (interrupt wins); EPC <= return PC (see Configuration); BD <= `BD_in` (0 when BD feature off).
- `EXL_clr`=1 and `Req`=0: EXL<=0. With EXL=1, `Req` is already 0, so `eret` never collides with entry.
- `WE` and `Req` same cycle: write discarded (instruction flushed), entry updates applied.
- `WE` to SR and `EXL_clr` same cycle: `EXL_clr` takes precedence over written EXL bit; IM/IE from `DATA_in`.

## Timing
- Reset (async, `reset`=0): SR, Cause, EPC = 0; `Req`=0, `EPC_out`=0, `DATA_out` = 0 except `addr`=15 gives `PRID`.
- Device IRQ asserted at edge N → Cause.IP set at edge N+1 → `Req` high during cycle N+1 (if unmasked) → EXL set at edge N+2, `Req` drops.
- `mtc0` SR visible to `Req` logic the cycle after the write edge.
- `DATA_out` reflects pre-edge register values; no write-to-read bypass.
- Reset deassertion mid-IRQ: IP samples on first active edge after release; `Req` no earlier than cycle after.

## Configuration
- `CP0_BD_EN` defined: Cause.BD implemented; on entry with `BD_in`=1, EPC <= `PC`-4 and BD<=1; else EPC <= `PC`, BD<=0.
- Not defined: BD bit reads 0, `BD_in` ignored, EPC <= `PC` always.

## Test plan
- Reset low mid-cycle with SR=32'h0000_0401 → all registers 0 immediately; `DATA_out`(addr 15)=32'h1935_0001.
- `mtc0` SR=32'h0000_0401, `HWInt`=6'b000001 at edge N, `PC`=32'h0000_3010 → `Req`=1 in cycle N+1; after edge N+2 Cause=32'h0000_0400, EPC=32'h0000_3010, SR=32'h0000_0403, `Req`=0.
- Same with IM=0 (SR=32'h1) → `Req` never asserts; Cause.IP[10] still reads 1.
- `ExcCode_in`=5'd12 and unmasked `HWInt`[0] same cycle → Cause.ExcCode=0 (interrupt priority); then `EXL_clr` → EXL=0, `Req` reasserts next cycle while IRQ held.
- With `CP0_BD_EN`: exception, `BD_in`=1, `PC`=32'h0000_3004 → EPC=32'h0000_3000, Cause[31]=1; without macro → EPC=32'h0000_3004, Cause[31]=0.
- `WE` to EPC with `DATA_in`=32'h1234_5677 and `Req`=0 → EPC reads 32'h1234_5674; same write with `Req`=1 → write discarded.
